// File: rtl/kbd_pkg.sv
// Shared types and event-field helpers for the keyboard matrix scanner.
package kbd_pkg;

    // Scan sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2,
        PROC    = 2'd3
    } scan_state_t;

    // Row index field width, at least one bit
    function automatic int rw_of(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    // Column index field width, at least one bit
    function automatic int cw_of(input int cols);
        return (cols > 1) ? $clog2(cols) : 1;
    endfunction

    // Full event width: {press, row_idx, col_idx}
    function automatic int evt_w_of(input int rows, input int cols);
        return 1 + rw_of(rows) + cw_of(cols);
    endfunction

    // Bit position of the press/release flag inside an event (the MSB)
    function automatic int press_bit_of(input int rows, input int cols);
        return rw_of(rows) + cw_of(cols);
    endfunction

endpackage

// File: rtl/kbd_matrix_scanner_fifo.sv
// Small registered event FIFO; a push while full is accepted only if a pop
// frees the slot in the same cycle, otherwise it is reported as a drop.
module kbd_event_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] data,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign drop      = push && !w_do_push;
    // Head entry is shown only when valid so the output reads zero when empty
    assign data      = empty ? '0 : r_mem[r_rd_ptr];

    // Storage array: written on accepted pushes, no reset needed
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

endmodule

// File: rtl/kbd_matrix_scanner.sv
// Keyboard matrix scanner: drives one column at a time, samples the rows,
// debounces every key independently and queues press/release events.
module kbd_matrix_scanner
    import kbd_pkg::*;
#(
    parameter int ROWS       = 9,
    parameter int COLS       = 10,
    parameter int SETTLE     = 4,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  scan_en,
    input  logic [ROWS-1:0]                       kbd_row,
    output logic [COLS-1:0]                       kbd_col,
    output logic [kbd_pkg::evt_w_of(ROWS,COLS)-1:0] evt_data,
    output logic                                  evt_valid,
    input  logic                                  evt_ready,
    output logic [ROWS*COLS-1:0]                  key_state,
    output logic                                  overflow,
    input  logic                                  overflow_clr,
    output logic                                  scan_tick
);
    localparam int RW   = rw_of(ROWS);
    localparam int CW   = cw_of(COLS);
    localparam int EW   = evt_w_of(ROWS, COLS);
    localparam int KEYS = ROWS * COLS;
    localparam int KW   = (KEYS > 1) ? $clog2(KEYS) : 1;
    localparam int CNTW = $clog2(DEBOUNCE + 1);
    localparam int SW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [ROWS-1:0]  r_row_meta;
    logic [ROWS-1:0]  r_row_sync;
    scan_state_t      r_state;
    logic [CW-1:0]    r_col_idx;
    logic [RW-1:0]    r_row_idx;
    logic [SW-1:0]    r_settle_cnt;
    logic [ROWS-1:0]  r_snap;
    logic [COLS-1:0]  r_kbd_col;
    logic             r_scan_tick;
    logic [KEYS-1:0]  r_key_state;
    logic [CNTW-1:0]  r_cnt [KEYS];
    logic             r_overflow;

    logic [KW-1:0]    w_key_idx;
    logic             w_snap_bit;
    logic             w_differs;
    logic [CNTW-1:0]  w_cnt_cur;
    logic             w_flip;
    logic             w_last_row;
    logic             w_last_col;
    logic [CW-1:0]    w_next_col;
    logic [EW-1:0]    w_push_data;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_fifo_drop;
    logic [EW-1:0]    w_fifo_data;

    assign w_key_idx   = KW'(r_col_idx) * KW'(ROWS) + KW'(r_row_idx);
    assign w_snap_bit  = r_snap[r_row_idx];
    assign w_differs   = (w_snap_bit != r_key_state[w_key_idx]);
    assign w_cnt_cur   = r_cnt[w_key_idx];
    // A key flips (and an event is pushed) on its DEBOUNCE-th consecutive differing scan
    assign w_flip      = (r_state == PROC) && w_differs && (w_cnt_cur == CNTW'(DEBOUNCE - 1));
    assign w_last_row  = (r_row_idx == RW'(ROWS - 1));
    assign w_last_col  = (r_col_idx == CW'(COLS - 1));
    assign w_next_col  = w_last_col ? '0 : r_col_idx + CW'(1);
    assign w_push_data = {w_snap_bit, r_row_idx, r_col_idx};

    // Two-flop synchroniser for the asynchronous row sense lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_meta <= '0;
            r_row_sync <= '0;
        end else begin
            r_row_meta <= kbd_row;
            r_row_sync <= r_row_meta;
        end
    end

    // Scan sequencer with registered column drive and end-of-scan pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_col_idx    <= '0;
            r_row_idx    <= '0;
            r_settle_cnt <= '0;
            r_snap       <= '0;
            r_kbd_col    <= '0;
            r_scan_tick  <= 1'b0;
        end else begin
            r_scan_tick <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (scan_en) begin
                        r_state      <= DRIVE;
                        r_col_idx    <= '0;
                        r_settle_cnt <= '0;
                        r_kbd_col    <= COLS'(1);
                    end
                end
                DRIVE: begin
                    if (r_settle_cnt == SW'(SETTLE - 1)) begin
                        r_state <= CAPTURE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + SW'(1);
                    end
                end
                CAPTURE: begin
                    r_snap    <= r_row_sync;
                    r_row_idx <= '0;
                    r_kbd_col <= '0;
                    r_state   <= PROC;
                end
                PROC: begin
                    if (w_last_row) begin
                        // The current column always completes before honouring scan_en
                        r_col_idx    <= w_next_col;
                        r_settle_cnt <= '0;
                        r_scan_tick  <= w_last_col;
                        if (scan_en) begin
                            r_state   <= DRIVE;
                            r_kbd_col <= COLS'(1) << w_next_col;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_row_idx <= r_row_idx + RW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Per-key debounce counters and debounced state, one key per PROC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_state <= '0;
            for (int k = 0; k < KEYS; k++) begin
                r_cnt[k] <= '0;
            end
        end else if (r_state == PROC) begin
            if (!w_differs) begin
                r_cnt[w_key_idx] <= '0;
            end else if (w_flip) begin
                r_key_state[w_key_idx] <= ~r_key_state[w_key_idx];
                r_cnt[w_key_idx]       <= '0;
            end else begin
                r_cnt[w_key_idx] <= w_cnt_cur + CNTW'(1);
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_fifo_drop && w_fifo_full) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    kbd_event_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_flip),
        .push_data (w_push_data),
        .pop       (evt_ready),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .data      (w_fifo_data),
        .drop      (w_fifo_drop)
    );

    assign kbd_col   = r_kbd_col;
    assign evt_data  = w_fifo_data;
    assign evt_valid = !w_fifo_empty;
    assign key_state = r_key_state;
    assign overflow  = r_overflow;
    assign scan_tick = r_scan_tick;

endmodule

// File: tb/tb_kbd_matrix_scanner.sv
// Directed bench for kbd_matrix_scanner with default parameters (9x10 matrix).
module tb_kbd_matrix_scanner;

    localparam int ROWS = 9;
    localparam int COLS = 10;
    localparam int KEYS = ROWS * COLS;
    localparam int SCAN = 140;   // 10 columns x (4 settle + 1 capture + 9 rows)

    logic            clk;
    logic            rst_n;
    logic            scan_en;
    logic [ROWS-1:0] kbd_row;
    logic [COLS-1:0] kbd_col;
    logic [8:0]      evt_data;
    logic            evt_valid;
    logic            evt_ready;
    logic [KEYS-1:0] key_state;
    logic            overflow;
    logic            overflow_clr;
    logic            scan_tick;

    logic [KEYS-1:0] key_down;
    int              n_cmp;
    int              n_bad;
    int              cyc;
    logic [8:0]      ev_q[$];
    int              ev_cyc[$];

    kbd_matrix_scanner dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scan_en      (scan_en),
        .kbd_row      (kbd_row),
        .kbd_col      (kbd_col),
        .evt_data     (evt_data),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .key_state    (key_state),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .scan_tick    (scan_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Matrix model: a held key connects its column drive to its row line
    always_comb begin
        kbd_row = '0;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (kbd_col[c] && key_down[c*ROWS + r]) kbd_row[r] = 1'b1;
            end
        end
    end

    // Record every event that will be popped at the next rising edge
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            ev_q.push_back(evt_data);
            ev_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] ev(input int p, input int r, input int c);
        return 9'(p*256 + r*16 + c);
    endfunction

    function automatic logic [KEYS-1:0] kb(input int k);
        logic [KEYS-1:0] m;
        m = '0;
        m[k] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Must be called at a falling edge; returns at the falling edge inside a scan_tick pulse
    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (scan_tick) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scan_tick_timeout: got none in 400 cycles expected one every %0d", SCAN);
        end
    endtask

    typedef struct {
        logic [KEYS-1:0] mask;
        int              scans;
        int              n_exp;
        logic [8:0]      exp_ev [2];
        int              gap;
        logic [KEYS-1:0] exp_state;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [KEYS-1:0] held;
        logic [KEYS-1:0] col0;
        int t1, t2;
        bit found;

        n_cmp = 0; n_bad = 0; cyc = 0;
        key_down = '0;
        rst_n = 1'b0; scan_en = 1'b0; evt_ready = 1'b1; overflow_clr = 1'b0;

        held = kb(11) | kb(46) | kb(51);
        col0 = KEYS'(9'h1FF);

        // Press row3 on col2/col4, short release bounce, re-press, long release,
        // row2/col1 press, then rows 1 and 6 of col5 together.
        vecs[0] = '{kb(21)|kb(39), 6,  2, '{ev(1,3,2), ev(1,3,4)}, 28, kb(21)|kb(39)};
        vecs[1] = '{'0,            2,  0, '{9'h0, 9'h0},            0, kb(21)|kb(39)};
        vecs[2] = '{kb(21)|kb(39), 6,  0, '{9'h0, 9'h0},            0, kb(21)|kb(39)};
        vecs[3] = '{'0,            20, 2, '{ev(0,3,2), ev(0,3,4)}, 28, '0};
        vecs[4] = '{kb(11),        5,  1, '{ev(1,2,1), 9'h0},       0, kb(11)};
        vecs[5] = '{held,          6,  2, '{ev(1,1,5), ev(1,6,5)},  5, held};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_kbd_col", kbd_col, 0);
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_evt_data", evt_data, 0);
        chk("rst_key_state", key_state, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_scan_tick", scan_tick, 0);
        rst_n = 1'b1;

        // Idle while scan_en is low
        repeat (10) @(negedge clk);
        chk("idle_kbd_col", kbd_col, 0);
        scan_en = 1'b1;

        for (int v = 0; v < 6; v++) begin
            wait_tick();
            ev_q.delete();
            ev_cyc.delete();
            key_down = vecs[v].mask;
            repeat (vecs[v].scans * SCAN) @(negedge clk);
            $display("vec %0d: %0d events, key_state=%0h", v, ev_q.size(), key_state);
            chk($sformatf("v%0d_event_count", v), ev_q.size(), vecs[v].n_exp);
            for (int i = 0; i < vecs[v].n_exp; i++) begin
                if (i < ev_q.size()) chk($sformatf("v%0d_event%0d", v, i), ev_q[i], vecs[v].exp_ev[i]);
            end
            if (vecs[v].gap != 0 && ev_cyc.size() >= 2)
                chk($sformatf("v%0d_event_gap", v), ev_cyc[1] - ev_cyc[0], vecs[v].gap);
            chk($sformatf("v%0d_key_state", v), key_state, vecs[v].exp_state);
        end

        // Overflow: nine presses in col0 with the FIFO stalled
        @(posedge clk); #1 evt_ready = 1'b0;
        @(negedge clk);
        wait_tick();
        key_down = held | col0;
        repeat (6 * SCAN) @(negedge clk);
        chk("ovf_valid", evt_valid, 1);
        chk("ovf_flag", overflow, 1);
        chk("ovf_key_state", key_state, held | col0);
        @(posedge clk); #1 overflow_clr = 1'b1;
        @(posedge clk); #1 overflow_clr = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", overflow, 0);
        ev_q.delete();
        ev_cyc.delete();
        @(posedge clk); #1 evt_ready = 1'b1;
        repeat (20) @(negedge clk);
        $display("overflow drain: %0d events", ev_q.size());
        chk("ovf_drain_count", ev_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < ev_q.size()) chk($sformatf("ovf_event%0d", i), ev_q[i], ev(1, i, 0));
        end
        chk("ovf_drain_valid", evt_valid, 0);

        // Reset mid-PROC with a full FIFO of release events
        @(posedge clk); #1 evt_ready = 1'b0;
        @(negedge clk);
        wait_tick();
        key_down = held;
        repeat (6 * SCAN) @(negedge clk);
        wait_tick();
        repeat (7) @(negedge clk);
        chk("prerst_valid", evt_valid, 1);
        rst_n = 1'b0;
        #1;
        $display("async reset: kbd_col=%0h valid=%0b key_state=%0h", kbd_col, evt_valid, key_state);
        chk("arst_kbd_col", kbd_col, 0);
        chk("arst_evt_valid", evt_valid, 0);
        chk("arst_evt_data", evt_data, 0);
        chk("arst_key_state", key_state, 0);
        chk("arst_overflow", overflow, 0);
        repeat (3) @(negedge clk);
        evt_ready = 1'b1;
        rst_n = 1'b1;

        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (kbd_col != '0) found = 1'b1;
        end
        chk("restart_col0", kbd_col, 1);

        wait_tick();
        t1 = cyc;
        @(negedge clk);
        wait_tick();
        t2 = cyc;
        $display("scan_tick period: %0d cycles", t2 - t1);
        chk("tick_period", t2 - t1, SCAN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
